// File: rtl/identifier_de.sv
// identifier_de: tracks min/max of a roll stream and reports the narrowest die whose bounds contain it.
// Optional IDENTIFIER_DE_BORNES_EN exposes the running extremes as min_obs/max_obs ports.
module identifier_de #(
    parameter int NB_MAX_TIRAGES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] valeur,
    input  logic       valeur_valide,
    input  logic       fin,
    output logic       pret,
    output logic [2:0] id_de,
    output logic       id_valide,
    output logic       erreur,
    output logic [7:0] nb_tirages
`ifdef IDENTIFIER_DE_BORNES_EN
    ,
    output logic [6:0] min_obs,
    output logic [6:0] max_obs
`endif
);
    typedef enum logic [1:0] {VIDE, ACCUM, CALCUL, RESULTAT} etat_t;
    localparam logic [7:0] NB_MAX = 8'(NB_MAX_TIRAGES);
    etat_t etat;
    logic [6:0] min_r, max_r;
    logic pret_etat, accepte, plein, bas, aucun;
    logic [2:0] id_sel;
    assign plein   = nb_tirages >= NB_MAX;
    assign pret    = rst_n && pret_etat;
    assign accepte = valeur_valide && pret_etat;
    always_comb begin
        pret_etat = (etat == CALCUL) ? 1'b0 : (etat == ACCUM) ? !plein : 1'b1;
    end
    // Dice 3 and 7 are the only ones whose range starts at 0.
    always_comb begin
        bas    = min_r != 7'd0;
        aucun  = max_r > 7'd99;
        id_sel = (bas && max_r <= 7'd4)  ? 3'd0 :
                 (bas && max_r <= 7'd6)  ? 3'd1 :
                 (bas && max_r <= 7'd8)  ? 3'd2 :
                 (max_r <= 7'd9)         ? 3'd3 :
                 (bas && max_r <= 7'd12) ? 3'd4 :
                 (bas && max_r <= 7'd20) ? 3'd5 :
                 (bas && max_r <= 7'd30) ? 3'd6 :
                 (max_r <= 7'd99)        ? 3'd7 : 3'd0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            etat       <= VIDE;
            id_de      <= 3'd0;
            id_valide  <= 1'b0;
            erreur     <= 1'b0;
            nb_tirages <= 8'd0;
            min_r      <= 7'd0;
            max_r      <= 7'd0;
        end else begin
            case (etat)
                VIDE, RESULTAT: begin
                    if (accepte) begin
                        min_r      <= valeur;
                        max_r      <= valeur;
                        nb_tirages <= 8'd1;
                        id_valide  <= 1'b0;
                        etat       <= ACCUM;
                    end else if (fin && etat == VIDE) begin
                        nb_tirages <= 8'd0;
                        erreur     <= 1'b1;
                        id_de      <= 3'd0;
                        id_valide  <= 1'b1;
                        etat       <= RESULTAT;
                    end
                end
                ACCUM: begin
                    if (accepte) begin
                        min_r      <= (valeur < min_r) ? valeur : min_r;
                        max_r      <= (valeur > max_r) ? valeur : max_r;
                        nb_tirages <= nb_tirages + 8'd1;
                    end
                    if (fin) etat <= CALCUL;
                end
                CALCUL: begin
                    id_de     <= id_sel;
                    erreur    <= aucun;
                    id_valide <= 1'b1;
                    etat      <= RESULTAT;
                end
                default: etat <= VIDE;
            endcase
        end
    end
`ifdef IDENTIFIER_DE_BORNES_EN
    assign min_obs = min_r;
    assign max_obs = max_r;
`endif
endmodule

// File: tb/tb_identifier_de.sv
// tb_identifier_de: directed sequences checked every cycle against a sample-queue model of the die identifier.
module tb_identifier_de;
    localparam int NB = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] valeur = '0;
    logic valeur_valide = 1'b0;
    logic fin = 1'b0;
    logic pret, id_valide, erreur;
    logic [2:0] id_de;
    logic [7:0] nb_tirages;
`ifdef IDENTIFIER_DE_BORNES_EN
    logic [6:0] min_obs, max_obs;
`endif
    int nv = 0;
    int ne = 0;
    bit go = 0;

    identifier_de #(.NB_MAX_TIRAGES(NB)) dut (
        .clk(clk), .rst_n(rst_n), .valeur(valeur), .valeur_valide(valeur_valide), .fin(fin),
        .pret(pret), .id_de(id_de), .id_valide(id_valide), .erreur(erreur), .nb_tirages(nb_tirages)
`ifdef IDENTIFIER_DE_BORNES_EN
        , .min_obs(min_obs), .max_obs(max_obs)
`endif
    );

    always #5 clk = ~clk;

    int tmin [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
    int tmax [8] = '{4, 6, 8, 9, 12, 20, 30, 99};
    int q [$];
    bit coll = 0, pend = 0, rv = 0, rerr = 0;
    int rid = 0, rnb = 0;
    int mn, mx;
    bit acc, wc;

    function automatic bit m_pret();
        return !pend && !(coll && q.size() >= NB);
    endfunction

    // Model: a sequence is the list of accepted samples; the verdict is a table search over its extremes.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            coll = 0; pend = 0; rv = 0; rerr = 0; rid = 0; rnb = 0;
        end else if (pend) begin
            mn = 127; mx = 0;
            foreach (q[i]) begin
                if (q[i] < mn) mn = q[i];
                if (q[i] > mx) mx = q[i];
            end
            rid = 0; rerr = 1;
            for (int i = 0; i < 8; i++)
                if (rerr && tmin[i] <= mn && mx <= tmax[i]) begin rid = i; rerr = 0; end
            rnb = q.size(); rv = 1; pend = 0; coll = 0;
        end else begin
            acc = valeur_valide && m_pret();
            wc = coll;
            if (acc) begin
                if (!coll) begin q.delete(); coll = 1; rv = 0; end
                q.push_back(int'(valeur));
            end
            if (fin && wc) pend = 1;
            else if (fin && !wc && !acc && !rv) begin rv = 1; rerr = 1; rid = 0; rnb = 0; end
        end
    end

    task automatic ck(input string n, input logic [31:0] a, input logic [31:0] e);
        nv++;
        if (a !== e) begin
            ne++;
            $display("FAIL %s: got %0d, want %0d", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (go) begin
            ck("pret", 32'(pret), 32'(rst_n && m_pret()));
            ck("id_valide", 32'(id_valide), 32'(rv));
            ck("nb_tirages", 32'(nb_tirages), coll ? q.size() : rnb);
            if (rv) begin
                ck("id_de", 32'(id_de), rid);
                ck("erreur", 32'(erreur), 32'(rerr));
            end
        end
    end

    task automatic step(input logic [6:0] v, input logic vv, input logic f);
        @(posedge clk);
        #2;
        valeur = v; valeur_valide = vv; fin = f;
    endtask

    task automatic wait_res(input string n, input int lat);
        int k = 0;
        do begin
            step(7'd0, 1'b0, 1'b0);
            k++;
            #1;
        end while (!id_valide && k < 10);
        ck({n, "_lat"}, k, lat);
    endtask

    task automatic res(input string n, input int id, input int err, input int nb);
        ck({n, "_v"}, 32'(id_valide), 1);
        ck({n, "_id"}, 32'(id_de), id);
        ck({n, "_err"}, 32'(erreur), err);
        ck({n, "_nb"}, 32'(nb_tirages), nb);
        ck({n, "_model_id"}, rid, id);
        ck({n, "_model_nb"}, rnb, nb);
    endtask

    initial begin
        @(posedge clk);
        go = 1;
        repeat (2) step(7'd0, 1'b0, 1'b0);
        #1;
        ck("rst_pret", 32'(pret), 0);
        ck("rst_valid", 32'(id_valide), 0);
        ck("rst_nb", 32'(nb_tirages), 0);
        ck("rst_err", 32'(erreur), 0);
        ck("rst_id", 32'(id_de), 0);
        @(posedge clk); #2; rst_n = 1'b1; #1;
        ck("rel_pret", 32'(pret), 1);
        step(7'd3, 1, 0); step(7'd1, 1, 0); step(7'd4, 1, 0); step(7'd0, 0, 1);
        wait_res("a", 2); res("a", 0, 0, 3);
        step(7'd0, 1, 0); step(7'd5, 1, 0); step(7'd0, 0, 1);
        wait_res("b", 2); res("b", 3, 0, 2);
        step(7'd0, 1, 0); step(7'd15, 1, 0); step(7'd0, 0, 1);
        wait_res("c", 2); res("c", 7, 0, 2);
        step(7'd1, 1, 0); step(7'd8, 1, 1);
        wait_res("d", 2); res("d", 2, 0, 2);
        step(7'd100, 1, 0); step(7'd0, 0, 1);
        wait_res("e", 2); res("e", 0, 1, 1);
        @(posedge clk); #2; rst_n = 1'b0;
        @(posedge clk); #2; rst_n = 1'b1;
        step(7'd0, 0, 1);
        wait_res("f", 1); res("f", 0, 1, 0);
        step(7'd1, 1, 0); step(7'd2, 1, 0); step(7'd3, 1, 0); step(7'd4, 1, 0);
        step(7'd30, 1, 0); #1;
        ck("g_full", 32'(pret), 0);
        step(7'd30, 1, 0); step(7'd0, 0, 1);
        wait_res("g", 2); res("g", 0, 0, 4);
        step(7'd20, 1, 0); step(7'd0, 0, 0); #1;
        ck("h_drop", 32'(id_valide), 0);
        step(7'd0, 0, 1);
        wait_res("h", 2); res("h", 5, 0, 1);
        step(7'd0, 0, 1); step(7'd0, 0, 0); step(7'd0, 0, 0); #1;
        res("h_hold", 5, 0, 1);
        step(7'd5, 1, 0); step(7'd6, 1, 0); step(7'd0, 0, 0);
        rst_n = 1'b0; #1;
        ck("i_pret_rst", 32'(pret), 0);
        @(posedge clk); #1;
        ck("i_nb", 32'(nb_tirages), 0);
        ck("i_valid", 32'(id_valide), 0);
        ck("i_err", 32'(erreur), 0);
        ck("i_id", 32'(id_de), 0);
        #1; rst_n = 1'b1; #1;
        ck("i_pret", 32'(pret), 1);
        step(7'd0, 0, 1);
        wait_res("i", 1); res("i", 0, 1, 0);
        repeat (2) step(7'd0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nv, ne);
        $finish;
    end
endmodule
